// File: rtl/chan_acc_pkg.sv
// Shared constants, output-width calculation and mux-select encoding for chan_acc.
package chan_acc_pkg;

  localparam int DEF_BITWIDTH_IN     = 9;
  localparam int DEF_ACC_LEN_BITS    = 7;
  localparam int DEF_N_CHAN_BITS     = 3;
  localparam int DEF_UNSIGNED        = 1;
  localparam int DEF_MULTIPLEX_DELAY = 2;

  // Accumulating 2^acc_len_bits samples needs acc_len_bits headroom bits.
  function automatic int calc_bitwidth_out(input int acc_len_bits, input int bitwidth_in);
    return acc_len_bits + bitwidth_in;
  endfunction

  typedef enum logic {
    SEL_DUMP,
    SEL_CHAIN
  } mux_sel_t;

endpackage

// File: rtl/chan_acc_delay.sv
// Fixed-depth register pipeline; RESETTABLE=1 gives every stage a synchronous clear.
module chan_acc_delay #(
  parameter int WIDTH      = 1,
  parameter int DEPTH      = 2,
  parameter int RESETTABLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Tap 0 is the input, tap DEPTH is the output; DEPTH=0 degenerates to a wire.
  logic [(DEPTH+1)*WIDTH-1:0] taps;

  assign taps[WIDTH-1:0] = din;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (RESETTABLE != 0 && rst) begin
          q_reg <= '0;
        end else begin
          q_reg <= taps[gi*WIDTH +: WIDTH];
        end
      end

      assign taps[(gi+1)*WIDTH +: WIDTH] = q_reg;
    end
  endgenerate

  assign dout = taps[DEPTH*WIDTH +: WIDTH];

endmodule

// File: rtl/chan_acc.sv
// Time-multiplexed per-channel spectrum accumulator with a chained output mux.
// Optional sticky collision flag is built when CHAN_ACC_COLLISION_EN is defined.
module chan_acc
  import chan_acc_pkg::*;
#(
  parameter int BITWIDTH_IN     = DEF_BITWIDTH_IN,
  parameter int ACC_LEN_BITS    = DEF_ACC_LEN_BITS,
  parameter int N_CHAN_BITS     = DEF_N_CHAN_BITS,
  parameter int UNSIGNED        = DEF_UNSIGNED,
  parameter int MULTIPLEX_DELAY = DEF_MULTIPLEX_DELAY,
  localparam int BITWIDTH_OUT   = calc_bitwidth_out(ACC_LEN_BITS, BITWIDTH_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync,
  input  logic                    din_vld,
  input  logic [BITWIDTH_IN-1:0]  din,
  input  logic [BITWIDTH_OUT-1:0] acc_in,
  input  logic [N_CHAN_BITS-1:0]  chan_in,
  input  logic                    valid_in,
  output logic [BITWIDTH_OUT-1:0] acc_out,
  output logic [N_CHAN_BITS-1:0]  chan_out,
  output logic                    valid_out
`ifdef CHAN_ACC_COLLISION_EN
  ,
  output logic                    collision
`endif
);

  localparam int N_CHAN = 1 << N_CHAN_BITS;

  logic [N_CHAN_BITS-1:0]  chan_cnt_reg, chan_cnt_next, chan_cur;
  logic [ACC_LEN_BITS-1:0] spec_cnt_reg, spec_cnt_next, spec_cur;

  // Distributed RAM: the accumulate path needs the stored word in the sample cycle.
  logic [BITWIDTH_OUT-1:0] acc_mem [N_CHAN];

  logic [BITWIDTH_OUT-1:0] din_ext, stored, sum, wr_data;
  logic                    dump;
  mux_sel_t                mux_sel;
  logic [BITWIDTH_OUT-1:0] mux_data;
  logic [N_CHAN_BITS-1:0]  mux_chan;
  logic                    mux_valid;

  generate
    if (UNSIGNED != 0) begin : g_zext
      assign din_ext = {{ACC_LEN_BITS{1'b0}}, din};
    end else begin : g_sext
      assign din_ext = {{ACC_LEN_BITS{din[BITWIDTH_IN-1]}}, din};
    end
  endgenerate

  // A sample arriving with sync is channel 0 of spectrum 0 of a fresh window.
  always_comb begin
    chan_cur      = sync ? '0 : chan_cnt_reg;
    spec_cur      = sync ? '0 : spec_cnt_reg;
    chan_cnt_next = chan_cnt_reg;
    spec_cnt_next = spec_cnt_reg;
    if (din_vld) begin
      chan_cnt_next = chan_cur + 1'b1;
      spec_cnt_next = (&chan_cur) ? spec_cur + 1'b1 : spec_cur;
    end else if (sync) begin
      chan_cnt_next = '0;
      spec_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan_cnt_reg <= '0;
      spec_cnt_reg <= '0;
    end else begin
      chan_cnt_reg <= chan_cnt_next;
      spec_cnt_reg <= spec_cnt_next;
    end
  end

  assign stored  = acc_mem[chan_cur];
  assign sum     = stored + din_ext;
  assign wr_data = (spec_cur == '0) ? din_ext : sum;
  assign dump    = din_vld && !rst && (&spec_cur);

  always_ff @(posedge clk) begin
    if (din_vld) begin
      acc_mem[chan_cur] <= wr_data;
    end
  end

  always_comb begin
    mux_sel   = dump ? SEL_DUMP : SEL_CHAIN;
    mux_data  = acc_in;
    mux_chan  = chan_in;
    mux_valid = valid_in;
    case (mux_sel)
      SEL_DUMP: begin
        mux_data  = sum;
        mux_chan  = chan_cur;
        mux_valid = 1'b1;
      end
      SEL_CHAIN: begin
        mux_data  = acc_in;
        mux_chan  = chan_in;
        mux_valid = valid_in;
      end
      default: ;
    endcase
  end

`ifdef CHAN_ACC_COLLISION_EN
  logic collision_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      collision_reg <= 1'b0;
    end else if (dump && valid_in) begin
      collision_reg <= 1'b1;
    end
  end

  assign collision = collision_reg;
`endif

  chan_acc_delay #(
    .WIDTH      (BITWIDTH_OUT + N_CHAN_BITS),
    .DEPTH      (MULTIPLEX_DELAY),
    .RESETTABLE (1)
  ) u_data_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({mux_data, mux_chan}),
    .dout ({acc_out, chan_out})
  );

  chan_acc_delay #(
    .WIDTH      (1),
    .DEPTH      (MULTIPLEX_DELAY),
    .RESETTABLE (1)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (mux_valid),
    .dout (valid_out)
  );

endmodule
